// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: funct3 size/sign encodings, FSM states,
// byte-enable patterns and the alignment rule used by the load/store stage.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Size lives in funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it according to funct3. Purely combinational.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage driving a req/ack data bus and stalling the pipe.
// Optional watchdog on outstanding accesses: define MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ALUOutIn,
  input  logic [XLEN-1:0] WriteDataIn,
  input  logic            MemReadIn,
  input  logic            MemWriteIn,
  input  logic [2:0]      Funct3In,
  input  logic            RegWriteIn,
  input  logic            MemToRegIn,
  input  logic [4:0]      WriteRegIn,
  output logic [XLEN-1:0] ReadDataOut,
  output logic [XLEN-1:0] ALUOutOut,
  output logic            RegWriteOut,
  output logic            MemToRegOut,
  output logic [4:0]      WriteRegOut,
  output logic            StallOut,
  output logic            MisalignOut,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            access;
  logic            misaligned;
  logic            start;
  logic            fault;
  logic [XLEN-1:0] lane_wdata;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] load_ext;

  assign access     = MemReadIn | MemWriteIn;
  assign misaligned = access & is_misaligned(Funct3In, ALUOutIn[1:0]);
  assign start      = (state_q == IDLE) & access & ~misaligned;

  always_comb begin
    lane_wdata = WriteDataIn;
    lane_be    = BE_WORD;
    case (Funct3In[1:0])
      2'b00: begin
        lane_wdata = {(XLEN/8){WriteDataIn[7:0]}};
        lane_be    = BE_BYTE << ALUOutIn[1:0];
      end
      2'b01: begin
        lane_wdata = {(XLEN/16){WriteDataIn[15:0]}};
        lane_be    = BE_HALF << {ALUOutIn[1], 1'b0};
      end
      default: ;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3  (funct3_q),
    .addr_lo (lane_q),
    .rdata   (dmem_rdata),
    .data    (load_ext)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             timeout_hit;

  assign timeout_hit = (state_q == BUSY) & ~(req_q & dmem_ack) &
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fault       = (state_q == DONE) & fault_q;

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (start)                   cnt_d = '0;
    else if (state_q == BUSY)    cnt_d = cnt_q + 1'b1;
    if (timeout_hit)             fault_d = 1'b1;
    else if (state_q == DONE)    fault_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
`else
  logic timeout_hit;
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = BUSY;
          req_d    = 1'b1;
          we_d     = MemWriteIn;  // store wins when both strobes are set
          addr_d   = {ALUOutIn[XLEN-1:2], 2'b00};
          wdata_d  = lane_wdata;
          be_d     = lane_be;
          funct3_d = Funct3In;
          lane_d   = ALUOutIn[1:0];
        end
      end
      BUSY: begin
        if (req_q && dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rdata_d = load_ext;
        end else if (timeout_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the read-data and bus registers are reset explicitly; they are plain flops, not memory arrays.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      funct3_q <= '0;
      lane_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      rdata_q  <= rdata_d;
    end
  end

  // Stall and fault strobes are gated by reset so they drop the moment reset asserts.
  assign StallOut    = rst & (start | (state_q == BUSY));
  assign MisalignOut = rst & (((state_q == IDLE) & misaligned) | fault);
  assign RegWriteOut = RegWriteIn & ~(((state_q == IDLE) & misaligned) | fault);

  assign ReadDataOut = rdata_q;
  assign ALUOutOut   = ALUOutIn;
  assign MemToRegOut = MemToRegIn;
  assign WriteRegOut = WriteRegIn;

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed loads/stores against a
// behavioural model, with hand-computed literal checks pinning the model.
module tb_mem_access_stage;

  localparam int TO_CYC = 4;

  logic        clk, rst;
  logic [31:0] ALUOutIn, WriteDataIn;
  logic        MemReadIn, MemWriteIn;
  logic [2:0]  Funct3In;
  logic        RegWriteIn, MemToRegIn;
  logic [4:0]  WriteRegIn;
  logic [31:0] ReadDataOut, ALUOutOut;
  logic        RegWriteOut, MemToRegOut;
  logic [4:0]  WriteRegOut;
  logic        StallOut, MisalignOut;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access_stage #(.XLEN(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .ALUOutIn(ALUOutIn), .WriteDataIn(WriteDataIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .Funct3In(Funct3In),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .WriteRegIn(WriteRegIn),
    .ReadDataOut(ReadDataOut), .ALUOutOut(ALUOutOut), .RegWriteOut(RegWriteOut),
    .MemToRegOut(MemToRegOut), .WriteRegOut(WriteRegOut),
    .StallOut(StallOut), .MisalignOut(MisalignOut),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of what the outputs must be this cycle
  logic        chk_en;
  logic        e_stall, e_mis, e_rw, e_req, e_we, e_m2r;
  logic [31:0] e_rd, e_addr, e_wdata, e_alu;
  logic [3:0]  e_be;
  logic [4:0]  e_wreg;
  logic [31:0] rd_model;

  int stall_seen = 0;
  int mis_seen   = 0;
  int req_seen   = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (w >> (8 * (a % 4))) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << (a % 4));
      2'b01:   return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h01010101;
      2'b01:   return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  always @(negedge clk) begin
    if (StallOut)    stall_seen++;
    if (MisalignOut) mis_seen++;
    if (dmem_req)    req_seen++;
    if (chk_en) begin
      check("stall", 32'(StallOut), 32'(e_stall));
      check("misalign", 32'(MisalignOut), 32'(e_mis));
      check("regwrite", 32'(RegWriteOut), 32'(e_rw));
      check("dmem_req", 32'(dmem_req), 32'(e_req));
      check("read_data", ReadDataOut, e_rd);
      check("alu_pass", ALUOutOut, e_alu);
      check("wreg_pass", 32'(WriteRegOut), 32'(e_wreg));
      check("m2r_pass", 32'(MemToRegOut), 32'(e_m2r));
      if (e_req) begin
        check("dmem_we", 32'(dmem_we), 32'(e_we));
        check("dmem_addr", dmem_addr, e_addr);
        check("dmem_be", 32'(dmem_be), 32'(e_be));
        check("dmem_wdata", dmem_wdata, e_wdata);
      end
    end
  end

  task automatic set_idle();
    ALUOutIn = 32'h0; WriteDataIn = 32'h0; MemReadIn = 1'b0; MemWriteIn = 1'b0;
    Funct3In = 3'b000; RegWriteIn = 1'b0; MemToRegIn = 1'b0; WriteRegIn = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    e_stall = 1'b0; e_mis = 1'b0; e_rw = 1'b0; e_req = 1'b0; e_we = 1'b0;
    e_m2r = 1'b0; e_wreg = 5'd0; e_alu = 32'h0; e_rd = rd_model;
    e_addr = 32'h0; e_be = 4'h0; e_wdata = 32'h0;
  endtask

  // One instruction through the stage; ack_after=0 means the bus never answers.
  task automatic do_access(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic rd, input logic wr, input int ack_after,
                           input logic [31:0] word);
    logic mis, timed_out, store;
    int   limit;
    mis   = m_mis(f3, a);
    store = wr;
    ALUOutIn = a; WriteDataIn = wd; MemReadIn = rd; MemWriteIn = wr; Funct3In = f3;
    RegWriteIn = rd & ~wr; MemToRegIn = rd & ~wr; WriteRegIn = 5'd7;
    e_alu = a; e_wreg = 5'd7; e_m2r = rd & ~wr;
    e_stall = ~mis; e_mis = mis; e_rw = mis ? 1'b0 : (rd & ~wr); e_req = 1'b0;
    e_rd = rd_model;
    e_we = store; e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wdata = store ? m_wdata(f3, wd) : e_wdata;
    @(posedge clk); #1;
    if (!mis) begin
      timed_out = 1'b1;
      limit = (ack_after > 0) ? ack_after : TO_CYC;
      for (int k = 1; k <= limit; k++) begin
        e_stall = 1'b1; e_mis = 1'b0; e_req = 1'b1;
        dmem_ack = (k == ack_after); dmem_rdata = word;
        if (k == 1) begin
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
        end
        @(posedge clk); #1;
        if (k == ack_after) timed_out = 1'b0;
      end
      dmem_ack = 1'b0; dmem_rdata = 32'hBAD0BAD0;
      e_stall = 1'b0; e_req = 1'b0;
      if (timed_out) begin
        e_mis = 1'b1; e_rw = 1'b0;
      end else begin
        e_mis = 1'b0; e_rw = rd & ~wr;
        if (!store) rd_model = m_load(f3, a, word);
      end
      e_rd = rd_model;
      @(posedge clk); #1;
    end
    set_idle();
    @(posedge clk); #1;
  endtask

  int s0, m0, r0;

  initial begin
    chk_en = 1'b0;
    rd_model = 32'h0;
    rst = 1'b0;
    set_idle();
    #12;
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(StallOut), 32'h0);
    check("rst_rdata", ReadDataOut, 32'h0);
    check("rst_be", 32'(dmem_be), 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // LW, ack in second BUSY cycle
    s0 = stall_seen;
    do_access(3'b010, 32'h100, 32'h0, 1'b1, 1'b0, 2, 32'hDEADBEEF);
    check("lw_data", ReadDataOut, 32'hDEADBEEF);
    check("lw_stall_cycles", 32'(stall_seen - s0), 32'd3);
    check("lw_be", 32'(cap_be), 32'hF);

    do_access(3'b000, 32'h103, 32'h0, 1'b1, 1'b0, 1, 32'h80FF1122);
    check("lb_data", ReadDataOut, 32'hFFFFFF80);
    do_access(3'b100, 32'h103, 32'h0, 1'b1, 1'b0, 1, 32'h80FF1122);
    check("lbu_data", ReadDataOut, 32'h00000080);
    do_access(3'b001, 32'h102, 32'h0, 1'b1, 1'b0, 3, 32'h80FF1122);
    check("lh_data", ReadDataOut, 32'hFFFF80FF);
    do_access(3'b101, 32'h100, 32'h0, 1'b1, 1'b0, 1, 32'h1234F00D);
    check("lhu_data", ReadDataOut, 32'h0000F00D);

    // SB: data unchanged, lane enables and replication
    do_access(3'b000, 32'h201, 32'h000000A5, 1'b0, 1'b1, 1, 32'h0);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    check("sb_addr", cap_addr, 32'h200);
    check("sb_we", 32'(cap_we), 32'h1);
    check("sb_keeps_rdata", ReadDataOut, 32'h0000F00D);

    do_access(3'b001, 32'h306, 32'h0000BEEF, 1'b0, 1'b1, 2, 32'h0);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hBEEFBEEF);

    // Read and write both set: store wins
    do_access(3'b010, 32'h40C, 32'hCAFEF00D, 1'b1, 1'b1, 1, 32'h11111111);
    check("rw_store_wins", 32'(cap_we), 32'h1);
    check("rw_rdata_kept", ReadDataOut, 32'h0000F00D);

    // Misaligned LW and LH
    m0 = mis_seen; r0 = req_seen; s0 = stall_seen;
    do_access(3'b010, 32'h102, 32'h0, 1'b1, 1'b0, 1, 32'h0);
    check("mis_pulse", 32'(mis_seen - m0), 32'd1);
    check("mis_no_req", 32'(req_seen - r0), 32'd0);
    check("mis_no_stall", 32'(stall_seen - s0), 32'd0);
    do_access(3'b001, 32'h103, 32'h0, 1'b1, 1'b0, 1, 32'h0);

    // Stray ack with no request outstanding
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("stray_ack", ReadDataOut, 32'h0000F00D);

    // Reset while BUSY
    chk_en = 1'b0;
    ALUOutIn = 32'h500; MemReadIn = 1'b1; Funct3In = 3'b010; RegWriteIn = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(dmem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy_req", 32'(dmem_req), 32'h0);
    check("rst_busy_stall", 32'(StallOut), 32'h0);
    rd_model = 32'h0;
    set_idle();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_access(3'b010, 32'h504, 32'h0, 1'b1, 1'b0, 1, 32'h12345678);
    check("post_rst_lw", ReadDataOut, 32'h12345678);

`ifdef MEM_ACCESS_TIMEOUT_EN
    r0 = req_seen; m0 = mis_seen;
    do_access(3'b010, 32'h600, 32'h0, 1'b1, 1'b0, 0, 32'h0);
    check("to_req_cycles", 32'(req_seen - r0), 32'd4);
    check("to_fault_pulse", 32'(mis_seen - m0), 32'd1);
    check("to_rdata_kept", ReadDataOut, 32'h12345678);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the MEM/WB register (pipe4).
- Takes the ALU result as the address and performs LB/LH/LW/LBU/LHU/SB/SH/SW on a req/ack data-memory bus.
- Stalls the pipeline while an access is outstanding.
- Presents aligned, extended load data plus forwarded control to pipe4's inputs.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ALUOutIn  in  XLEN  effective address / ALU result.
- WriteDataIn  in  XLEN  store data from rs2.
- MemReadIn  in  1  load instruction.
- MemWriteIn  in  1  store instruction.
- Funct3In  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RegWriteIn  in  1  control, forwarded.
- MemToRegIn  in  1  control, forwarded.
- WriteRegIn  in  5  destination register, forwarded.
- ReadDataOut  out  XLEN  extended load data, to pipe4 ReadDataPipeIn.
- ALUOutOut  out  XLEN  ALUOutIn passthrough.
- RegWriteOut  out  1  RegWriteIn, forced 0 on fault.
- MemToRegOut  out  1  passthrough.
- WriteRegOut  out  5  passthrough.
- StallOut  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into pipe4.
- MisalignOut  out  1  one-cycle misaligned-access pulse.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  write enable.
- dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- dmem_wdata  out  XLEN  store data replicated into lanes.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  completion; valid only while dmem_req=1.
- dmem_rdata  in  XLEN  read word; valid with ack.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (rst=0, async) forces IDLE, dmem_req=0, rdata_q=0, all bus outputs 0, StallOut=0, MisalignOut=0. Reset mid-access abandons the access with no completion. The memory side must tolerate a dropped request.
- Access = MemReadIn|MemWriteIn. Misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0). Byte accesses are never misaligned.
- IDLE, no access: passthrough, StallOut=0.
- IDLE, access, misaligned: no request, MisalignOut=1, RegWriteOut=0, StallOut=0, stay IDLE.
- IDLE, access, aligned: StallOut=1. At the edge, latch we/addr/be/wdata and set dmem_req=1. Go to BUSY.
- BUSY: dmem_req and all bus outputs held stable. StallOut=1 until ack. On ack: rdata_q <= extended lane of dmem_rdata, dmem_req <= 0, go to DONE. StallOut stays 1 during the ack cycle.
- DONE: StallOut=0, ReadDataOut=rdata_q, pipeline advances. Next state IDLE unconditionally.
- Minimum latency with ack in the first BUSY cycle: 3 cycles, 2 stall cycles.
- Load lane select uses addr[1:0]. B/BU select byte addr[1:0], H/HU select halfword addr[1]. Signed forms sign-extend; unsigned forms zero-extend.
- Store byte enables: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111. wdata is the byte replicated x4 or the halfword replicated x2.
- Stores: ReadDataOut is don't-care; drive rdata_q unchanged.
- Outside DONE, ReadDataOut = rdata_q. pipe4 ignores it when MemToReg=0.
- MemReadIn and MemWriteIn both high is illegal. Store wins.
- Inputs are held stable by the upstream stall while StallOut=1.
- ack while dmem_req=0 is ignored.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- Defined: counter cleared on entering BUSY, increments each BUSY cycle. Reaching TIMEOUT_CYCLES without ack drops dmem_req, goes to DONE with RegWriteOut=0 and rdata_q unchanged, and pulses MisalignOut as a generic fault.
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package riscv_pkg: Funct3 load/store encodings, state enum mem_state_t, byte-enable constants.
- Sub-module load_align (combinational): funct3, addr[1:0], rdata -> extended data. Shared with store lane generation only if trivial; otherwise store logic stays inline.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> StallOut high 3 cycles, DONE ReadDataOut=0xDEADBEEF, dmem_be=1111.
- LB addr 0x103, rdata 0x80FF1122 -> ReadDataOut=0xFFFFFF80. Same with LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, data 0x000000A5 -> dmem_be=0010, dmem_wdata=0xA5A5A5A5, dmem_we=1, dmem_addr=0x200.
- LW addr 0x102 -> no dmem_req, MisalignOut 1-cycle pulse, RegWriteOut=0, StallOut=0.
- rst low in BUSY -> dmem_req=0 and StallOut=0 immediately. After release, state is IDLE and a new LW completes normally.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 BUSY cycles, fault pulse, RegWriteOut=0 in DONE.
